mult8_acc_stage: RTL and testbench
==================================

Name: mult8_acc_stage

Overview:
- Downstream consumer of the 8x8 combinational multiplier.
- Accepts 16-bit products over a valid/ready handshake and accumulates them into a wide sum, one group per dot product.
- Presents each group result on an output handshake with term count and status flags.
- Sits between the multiplier array and the result sink or writeback.

Parameters:
- ACC_W, 24, accumulator and result width in bits; must be at least 16.
- CNT_W, 8, term counter width in bits.
- MAX_TERMS, 255, maximum beats per group; must be at least 1 and at most 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous group abort; highest priority.
- prod_valid  input  1  product beat valid.
- prod_ready  output  1  stage can accept a beat.
- prod_data  input  16  unsigned product P from the multiplier.
- prod_last  input  1  final beat of the current group.
- res_valid  output  1  group result valid.
- res_ready  input  1  sink accepts the result.
- res_data  output  ACC_W  accumulated sum.
- res_count  output  CNT_W  number of beats in the group.
- res_ovf  output  1  sum exceeded 2^ACC_W-1 at some point in the group (sticky).
- res_forced  output  1  group closed by MAX_TERMS, not by prod_last.

Behaviour:
- Reset (rst_n=0, asynchronous): state=ACCUM; acc, cnt and ovf are 0; outputs prod_ready=1, res_valid=0, res_data=0, res_count=0, res_ovf=0, res_forced=0.
- States:
  - ACCUM: prod_ready=1, res_valid=0.
  - HOLD: prod_ready=0, res_valid=1, all res_* outputs held stable.
- Beat acceptance: a beat is accepted when prod_valid and prod_ready are both 1.
- On each accepted beat:
  - sum = acc + zero-extended prod_data, computed in ACC_W+1 bits.
  - Carry out of bit ACC_W-1 sets ovf.
  - acc_next = sum[ACC_W-1:0] (wrap).
  - cnt_next = cnt + 1.
- Group close: occurs on an accepted beat with prod_last=1, or when cnt_next == MAX_TERMS.
  - Next cycle: state=HOLD; res_data=acc_next; res_count=cnt_next; res_ovf=ovf including this beat.
  - res_forced=1 only if cnt_next == MAX_TERMS and prod_last=0. If both hold on the same beat, res_forced=0.
  - acc, cnt and ovf clear to 0 on the same edge.
- Latency: result is valid 1 cycle after the closing beat is accepted.
- HOLD to ACCUM: on res_valid and res_ready. prod_ready returns to 1 in the following cycle. There is no same-cycle bypass, so the minimum group period is beats+1 cycles.
- Single-beat group (prod_last on the first beat): res_data equals prod_data, res_count=1.
- Output hold: while in HOLD, prod_valid is ignored and the upstream stage stalls. Result fields must not change until the result is accepted.
- clr=1: next cycle state=ACCUM; acc, cnt and ovf are 0; res_valid=0.
  - A pending result in HOLD is discarded.
  - A beat presented in the same cycle as clr is dropped. prod_ready is still driven by the current state.
- res_ready while res_valid=0 has no effect.
- Reset mid-group: the partial sum is lost and there is no output.
- Inputs are sampled only on acceptance. prod_data need not be stable otherwise.

Optional Feature:
- Macro: MULT8_ACC_SAT_EN.
- Defined: on carry out, acc_next saturates to 2^ACC_W-1 and remains saturated for the rest of the group; ovf is still set.
- Undefined: modulo-2^ACC_W wrap as described above.
- res_ovf semantics are identical in both builds.

Test Plan:
- Reset then idle: after rst_n release, prod_ready=1, res_valid=0, all res_* outputs = 0; asserting rst_n=0 mid-group clears everything without waiting for a clock edge.
- Three beats of 65025 (255*255), last on the third, res_ready=1 -> one cycle later res_valid=1, res_data=195075, res_count=3, res_ovf=0, res_forced=0; prod_ready=0 for exactly one cycle.
- Backpressure: group {10, 20} with res_ready=0 for 5 cycles -> res_data=30 held stable and prod_ready=0 throughout; after res_ready=1, res_valid=0 and prod_ready=1 the next cycle.
- ACC_W=18, five beats of 65025 -> res_ovf=1; res_data=62981 when wrapping, 262143 with MULT8_ACC_SAT_EN.
- MAX_TERMS=4, six beats of 1 with no prod_last -> first result res_count=4, res_data=4, res_forced=1; the remaining beats form a new group, and prod_last on beat 6 gives res_count=2, res_forced=0.
- clr in HOLD and clr mid-group (after beats 7, 9) -> res_valid drops the next cycle; a following group {5} with last yields res_data=5, res_count=1.

Source files
------------

// File: rtl/mult8_acc_stage.sv
// Accumulates 16-bit multiplier products into per-group sums and hands each group
// result downstream over a valid/ready handshake. Define MULT8_ACC_SAT_EN to saturate instead of wrap.
module mult8_acc_stage #(
    parameter int ACC_W     = 24,
    parameter int CNT_W     = 8,
    parameter int MAX_TERMS = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [15:0]      prod_data,
    input  logic             prod_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic [CNT_W-1:0] res_count,
    output logic             res_ovf,
    output logic             res_forced
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ovf, ovf_nxt;
    logic [ACC_W-1:0] res_data_nxt;
    logic [CNT_W-1:0] res_count_nxt;
    logic             res_ovf_nxt, res_forced_nxt;

    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_add;
    logic [CNT_W-1:0] cnt_inc;
    logic             carry, at_max, accept;

    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    always_comb begin
        state_nxt      = state;
        acc_nxt        = acc;
        cnt_nxt        = cnt;
        ovf_nxt        = ovf;
        res_data_nxt   = res_data;
        res_count_nxt  = res_count;
        res_ovf_nxt    = res_ovf;
        res_forced_nxt = res_forced;
        prod_ready     = (state == ACCUM);
        res_valid      = (state == HOLD);

        accept  = prod_valid && (state == ACCUM);
        sum     = {1'b0, acc} + (ACC_W+1)'(prod_data);
        carry   = sum[ACC_W];
`ifdef MULT8_ACC_SAT_EN
        // Once saturated, acc is all ones, so any further nonzero beat carries again.
        acc_add = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        acc_add = sum[ACC_W-1:0];
`endif
        cnt_inc = cnt + CNT_W'(1);
        at_max  = (cnt_inc == CNT_W'(MAX_TERMS));

        if (clr) begin
            state_nxt = ACCUM;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (prod_last || at_max) begin
                            state_nxt      = HOLD;
                            res_data_nxt   = acc_add;
                            res_count_nxt  = cnt_inc;
                            res_ovf_nxt    = ovf | carry;
                            res_forced_nxt = at_max && !prod_last;
                            acc_nxt        = '0;
                            cnt_nxt        = '0;
                            ovf_nxt        = 1'b0;
                        end else begin
                            acc_nxt = acc_add;
                            cnt_nxt = cnt_inc;
                            ovf_nxt = ovf | carry;
                        end
                    end
                end
                HOLD: begin
                    if (res_ready) state_nxt = ACCUM;
                end
                default: state_nxt = ACCUM;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ACCUM;
            acc        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            res_data   <= '0;
            res_count  <= '0;
            res_ovf    <= 1'b0;
            res_forced <= 1'b0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            cnt        <= cnt_nxt;
            ovf        <= ovf_nxt;
            res_data   <= res_data_nxt;
            res_count  <= res_count_nxt;
            res_ovf    <= res_ovf_nxt;
            res_forced <= res_forced_nxt;
        end
    end

endmodule

// File: tb/tb_mult8_acc_stage.sv
// Directed bench for mult8_acc_stage: instance "a" (ACC_W=18) covers handshake, overflow,
// clear and reset; instance "b" (MAX_TERMS=4) covers forced group close.
module tb_mult8_acc_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        prod_valid = 1'b0;
    logic        prod_last = 1'b0;
    logic        res_ready = 1'b0;
    logic [15:0] prod_data = 16'd0;

    logic        a_prod_ready, a_res_valid, a_res_ovf, a_res_forced;
    logic [17:0] a_res_data;
    logic [7:0]  a_res_count;
    logic        b_prod_ready, b_res_valid, b_res_ovf, b_res_forced;
    logic [23:0] b_res_data;
    logic [7:0]  b_res_count;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [15:0] P255 = 16'd65025;
`ifdef MULT8_ACC_SAT_EN
    localparam int OVF_EXP = 262143;
`else
    localparam int OVF_EXP = 62981;
`endif

    mult8_acc_stage #(.ACC_W(18), .CNT_W(8), .MAX_TERMS(255)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .prod_valid(prod_valid), .prod_ready(a_prod_ready), .prod_data(prod_data), .prod_last(prod_last),
        .res_valid(a_res_valid), .res_ready(res_ready), .res_data(a_res_data),
        .res_count(a_res_count), .res_ovf(a_res_ovf), .res_forced(a_res_forced)
    );

    mult8_acc_stage #(.ACC_W(24), .CNT_W(8), .MAX_TERMS(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .prod_valid(prod_valid), .prod_ready(b_prod_ready), .prod_data(prod_data), .prod_last(prod_last),
        .res_valid(b_res_valid), .res_ready(res_ready), .res_data(b_res_data),
        .res_count(b_res_count), .res_ovf(b_res_ovf), .res_forced(b_res_forced)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat once the chosen instance is ready; returns #1 after the accepting edge.
    task automatic send(input logic [15:0] d, input logic last, input bit on_b);
        int waited = 0;
        @(negedge clk);
        while (!(on_b ? b_prod_ready : a_prod_ready) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("send_ready", {31'd0, on_b ? b_prod_ready : a_prod_ready}, 32'd1);
        prod_valid = 1'b1;
        prod_data  = d;
        prod_last  = last;
        @(posedge clk);
        #1;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        prod_data  = 16'hDEAD;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset then idle
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_prod_ready", a_prod_ready, 1);
        check("rst_res_valid", a_res_valid, 0);
        check("rst_res_data", a_res_data, 0);
        check("rst_res_count", a_res_count, 0);
        check("rst_res_ovf", a_res_ovf, 0);
        check("rst_res_forced", a_res_forced, 0);

        // Three beats of 255*255
        res_ready = 1'b1;
        send(P255, 1'b0, 1'b0);
        send(P255, 1'b0, 1'b0);
        check("g3_no_early_valid", a_res_valid, 0);
        send(P255, 1'b1, 1'b0);
        check("g3_valid", a_res_valid, 1);
        check("g3_data", a_res_data, 195075);
        check("g3_count", a_res_count, 3);
        check("g3_ovf", a_res_ovf, 0);
        check("g3_forced", a_res_forced, 0);
        check("g3_ready_low", a_prod_ready, 0);
        tick();
        check("g3_ready_back", a_prod_ready, 1);
        check("g3_valid_drop", a_res_valid, 0);

        // Asynchronous reset mid-group, between clock edges
        send(16'd3, 1'b0, 1'b0);
        send(16'd4, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_res_data", a_res_data, 0);
        check("arst_res_count", a_res_count, 0);
        check("arst_prod_ready", a_prod_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        send(16'd6, 1'b1, 1'b0);
        check("arst_partial_lost", a_res_data, 6);
        check("arst_count", a_res_count, 1);
        tick();

        // Backpressure: result held while sink stalls; beats offered in HOLD are ignored
        res_ready = 1'b0;
        send(16'd10, 1'b0, 1'b0);
        send(16'd20, 1'b1, 1'b0);
        check("bp_valid", a_res_valid, 1);
        @(negedge clk);
        prod_valid = 1'b1;
        prod_data  = 16'd99;
        prod_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_data", a_res_data, 30);
            check("bp_hold_ready", a_prod_ready, 0);
            check("bp_hold_valid", a_res_valid, 1);
        end
        check("bp_hold_count", a_res_count, 2);
        @(negedge clk);
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        res_ready  = 1'b1;
        tick();
        check("bp_release_valid", a_res_valid, 0);
        check("bp_release_ready", a_prod_ready, 1);

        // Overflow with ACC_W=18: five beats of 65025
        do_reset();
        for (int i = 0; i < 5; i++) send(P255, (i == 4), 1'b0);
        check("ovf_flag", a_res_ovf, 1);
        check("ovf_data", a_res_data, OVF_EXP);
        check("ovf_count", a_res_count, 5);
        check("ovf_forced", a_res_forced, 0);
        tick();

        // Forced close at MAX_TERMS=4, then remainder as a new group
        do_reset();
        for (int i = 0; i < 4; i++) send(16'd1, 1'b0, 1'b1);
        check("max_valid", b_res_valid, 1);
        check("max_count", b_res_count, 4);
        check("max_data", b_res_data, 4);
        check("max_forced", b_res_forced, 1);
        send(16'd1, 1'b0, 1'b1);
        send(16'd1, 1'b1, 1'b1);
        check("rem_valid", b_res_valid, 1);
        check("rem_count", b_res_count, 2);
        check("rem_data", b_res_data, 2);
        check("rem_forced", b_res_forced, 0);
        tick();

        // clr mid-group with a beat presented on the same cycle
        do_reset();
        send(16'd7, 1'b0, 1'b0);
        send(16'd9, 1'b0, 1'b0);
        @(negedge clk);
        clr        = 1'b1;
        prod_valid = 1'b1;
        prod_data  = 16'd50;
        prod_last  = 1'b1;
        tick();
        clr        = 1'b0;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        check("clr_mid_valid", a_res_valid, 0);
        check("clr_mid_ready", a_prod_ready, 1);
        send(16'd5, 1'b1, 1'b0);
        check("clr_mid_next_data", a_res_data, 5);
        check("clr_mid_next_count", a_res_count, 1);
        tick();

        // clr discards a pending result in HOLD
        res_ready = 1'b0;
        send(16'd8, 1'b1, 1'b0);
        check("clr_hold_pre_valid", a_res_valid, 1);
        @(negedge clk);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_hold_valid", a_res_valid, 0);
        check("clr_hold_ready", a_prod_ready, 1);
        res_ready = 1'b1;
        send(16'd5, 1'b1, 1'b0);
        check("clr_hold_next_data", a_res_data, 5);
        check("clr_hold_next_count", a_res_count, 1);
        check("clr_hold_next_ovf", a_res_ovf, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
